// File: rtl/alu_shift_seq.sv
// alu_shift_seq: multi-cycle SLL/SRL/SRA shifter, at most STEP positions per clock, valid/ready on both sides.
// Define ALU_SHIFT_ROTATE_EN to make op=11 a rotate-right; otherwise op=11 acts as SRL.
module alu_shift_seq #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rd
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] STEP_W = (SHW+1)'(STEP);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, shifted, sra;
  logic [SHW-1:0]   cnt_q, cnt_d, amt, cnt_left;
  logic [1:0]       op_q, op_d;
  logic             unused_rs2;
  assign unused_rs2 = ^rs2[WIDTH-1:SHW];
  // cnt never exceeds WIDTH-1, so amt fits in SHW bits even when STEP == WIDTH
  assign amt      = ({1'b0, cnt_q} < STEP_W) ? cnt_q : STEP_W[SHW-1:0];
  assign cnt_left = cnt_q - amt;
  assign sra      = $signed(acc_q) >>> amt;
`ifdef ALU_SHIFT_ROTATE_EN
  logic [2*WIDTH-1:0] rot;
  assign rot = {acc_q, acc_q} >> amt;
  always_comb
    shifted = (op_q == 2'b00) ? acc_q << amt :
              (op_q == 2'b10) ? sra :
              (op_q == 2'b11) ? rot[WIDTH-1:0] : acc_q >> amt;
`else
  always_comb
    shifted = (op_q == 2'b00) ? acc_q << amt :
              (op_q == 2'b10) ? sra : acc_q >> amt;
`endif
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    if (state_q == IDLE && in_valid) begin
      acc_d   = rs1;
      cnt_d   = rs2[SHW-1:0];
      op_d    = op;
      state_d = (rs2[SHW-1:0] != '0) ? SHIFT : DONE;
    end else if (state_q == SHIFT) begin
      acc_d   = shifted;
      cnt_d   = cnt_left;
      state_d = (cnt_left == '0) ? DONE : SHIFT;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign rd        = out_valid ? acc_q : '0;
endmodule

// File: tb/tb_alu_shift_seq.sv
// tb_alu_shift_seq: directed checks of the sequential shifter with STEP=1 and STEP=8 instances.
module tb_alu_shift_seq;
  logic        clk = 0, rst = 0, iv1 = 0, iv8 = 0, out_ready = 0;
  logic [1:0]  op = 0;
  logic [31:0] rs1 = 0, rs2 = 0;
  logic        ir1, ir8, ov1, ov8;
  logic [31:0] rd1, rd8;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  alu_shift_seq #(.WIDTH(32), .STEP(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .op(op), .rs1(rs1), .rs2(rs2),
    .out_valid(ov1), .out_ready(out_ready), .rd(rd1));
  alu_shift_seq #(.WIDTH(32), .STEP(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .op(op), .rs1(rs1), .rs2(rs2),
    .out_valid(ov8), .out_ready(out_ready), .rd(rd8));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input bit s8, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e, input int lat, input string nm);
    int n;
    total++;
    if ((s8 ? ir8 : ir1) !== 1'b1) begin
      bad++;
      $display("FAIL %s in_ready before accept got=%b want=1", nm, s8 ? ir8 : ir1);
    end
    op = o; rs1 = a; rs2 = b;
    if (s8) iv8 = 1; else iv1 = 1;
    tick();
    iv1 = 0; iv8 = 0; op = ~o; rs1 = ~a; rs2 = b + 7;
    n = 1;
    while ((s8 ? ov8 : ov1) !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    total++;
    if (n != lat) begin
      bad++;
      $display("FAIL %s latency got=%0d want=%0d", nm, n, lat);
    end
    total++;
    if ((s8 ? rd8 : rd1) !== e) begin
      bad++;
      $display("FAIL %s rd got=%h want=%h", nm, s8 ? rd8 : rd1, e);
    end
    out_ready = 1;
    tick();
    out_ready = 0;
    total++;
    if ((s8 ? ir8 : ir1) !== 1'b1 || (s8 ? ov8 : ov1) !== 1'b0) begin
      bad++;
      $display("FAIL %s release got in_ready=%b out_valid=%b want 1/0", nm, s8 ? ir8 : ir1, s8 ? ov8 : ov1);
    end
  endtask

  task automatic test_reset;
    rst = 1;
    tick();
    tick();
    rst = 0;
    total++;
    if ({ir1, ov1, rd1} !== {1'b1, 1'b0, 32'h0}) begin
      bad++;
      $display("FAIL reset_step1 got ir=%b ov=%b rd=%h want 1 0 0", ir1, ov1, rd1);
    end
    total++;
    if ({ir8, ov8, rd8} !== {1'b1, 1'b0, 32'h0}) begin
      bad++;
      $display("FAIL reset_step8 got ir=%b ov=%b rd=%h want 1 0 0", ir8, ov8, rd8);
    end
  endtask

  task automatic test_step1;
    do_op(0, 2'b01, 32'h2, 32'd1, 32'h1, 2, "srl_2_1");
    do_op(0, 2'b01, 32'h1, 32'd1, 32'h0, 2, "srl_1_1");
    do_op(0, 2'b01, 32'h80000000, 32'd1, 32'h40000000, 2, "srl_msb_1");
    do_op(0, 2'b10, 32'h80000000, 32'd4, 32'hF8000000, 5, "sra_neg_4");
    do_op(0, 2'b00, 32'h1, 32'd31, 32'h80000000, 32, "sll_1_31");
    do_op(0, 2'b01, 32'h80000000, 32'd33, 32'h40000000, 2, "srl_rs2_33");
    do_op(0, 2'b01, 32'hDEADBEEF, 32'd0, 32'hDEADBEEF, 1, "srl_zero_step1");
  endtask

  task automatic test_step8;
    do_op(1, 2'b01, 32'hFFFFFFFF, 32'd20, 32'h00000FFF, 4, "srl8_20");
    do_op(1, 2'b01, 32'h12345678, 32'd0, 32'h12345678, 1, "srl8_zero");
    do_op(1, 2'b10, 32'h70000000, 32'd4, 32'h07000000, 2, "sra8_pos_4");
    do_op(1, 2'b10, 32'h80000001, 32'd9, 32'hFFC00000, 3, "sra8_neg_9");
    do_op(1, 2'b00, 32'h1, 32'd31, 32'h80000000, 5, "sll8_1_31");
    do_op(1, 2'b00, 32'h000000FF, 32'd8, 32'h0000FF00, 2, "sll8_exact_step");
  endtask

  task automatic test_op11;
`ifdef ALU_SHIFT_ROTATE_EN
    do_op(0, 2'b11, 32'h1, 32'd1, 32'h80000000, 2, "op11_1_1");
    do_op(1, 2'b11, 32'h12345678, 32'd12, 32'h67812345, 3, "op11_step8_12");
`else
    do_op(0, 2'b11, 32'h1, 32'd1, 32'h0, 2, "op11_1_1");
    do_op(1, 2'b11, 32'h12345678, 32'd12, 32'h00012345, 3, "op11_step8_12");
`endif
  endtask

  task automatic test_backpressure;
    int n;
    op = 2'b10; rs1 = 32'hF0F00000; rs2 = 32'd2; iv1 = 1;
    tick();
    iv1 = 0;
    n = 1;
    while (ov1 !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    total++;
    if (n != 3) begin
      bad++;
      $display("FAIL bp_latency got=%0d want=3", n);
    end
    iv1 = 1; op = 2'b00; rs1 = 32'h5; rs2 = 32'd0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({ov1, ir1, rd1} !== {1'b1, 1'b0, 32'hFC3C0000}) begin
        bad++;
        $display("FAIL bp_hold[%0d] got ov=%b ir=%b rd=%h want 1 0 fc3c0000", i, ov1, ir1, rd1);
      end
      tick();
    end
    iv1 = 0;
    out_ready = 1;
    tick();
    out_ready = 0;
    total++;
    if ({ir1, ov1} !== 2'b10) begin
      bad++;
      $display("FAIL bp_release got ir=%b ov=%b want 1 0", ir1, ov1);
    end
    tick();
    total++;
    if ({ir1, ov1} !== 2'b10) begin
      bad++;
      $display("FAIL bp_no_stray_accept got ir=%b ov=%b want 1 0", ir1, ov1);
    end
  endtask

  task automatic test_reset_mid_op;
    op = 2'b00; rs1 = 32'h1; rs2 = 32'd20; iv1 = 1;
    tick();
    iv1 = 0;
    repeat (4) tick();
    total++;
    if (ir1 !== 1'b0) begin
      bad++;
      $display("FAIL midop_busy in_ready got=%b want=0", ir1);
    end
    rst = 1;
    tick();
    rst = 0;
    total++;
    if ({ir1, ov1, rd1} !== {1'b1, 1'b0, 32'h0}) begin
      bad++;
      $display("FAIL midop_reset got ir=%b ov=%b rd=%h want 1 0 0", ir1, ov1, rd1);
    end
    repeat (25) tick();
    total++;
    if (ov1 !== 1'b0) begin
      bad++;
      $display("FAIL midop_no_result out_valid got=%b want=0", ov1);
    end
    do_op(0, 2'b01, 32'h2, 32'd1, 32'h1, 2, "after_reset_srl");
  endtask

  task automatic test_back_to_back;
    do_op(1, 2'b01, 32'hA5A5A5A5, 32'd4, 32'h0A5A5A5A, 2, "b2b_first");
    do_op(1, 2'b00, 32'hA5A5A5A5, 32'd4, 32'h5A5A5A50, 2, "b2b_second");
  endtask

  initial begin
    tick();
    test_reset();
    test_step1();
    test_step8();
    test_op11();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
